// File: rtl/i2c_target.sv
// I2C target: 7-bit address, up to 4-byte write into rx_data, 4-byte read from latched tx_data.
// Ports: clk/reset, raw scl_i/sda_i, open-drain sda_o/sda_oe, tx_data in, rx_data/rx_mask/rx_valid/busy/acks out.
// Latency: bus lines pass a 2-flop synchronizer; SDA reacts on the 2nd cycle after a synced SCL edge. Never stretches SCL.
module i2c_target #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h42,
  parameter int unsigned BYTE_START  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oe,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic [3:0]  rx_mask,
  output logic        rx_valid,
  output logic        busy,
  output logic [3:0]  acks
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  localparam logic [1:0] IDX_FIRST = 2'(BYTE_START);

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;
  logic r_rise_d, r_fall_d;

  logic w_start, w_stop, w_rise, w_fall;

  state_t      r_state;
  logic [3:0]  r_bitcnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_shift;
  logic [31:0] r_tx;
  logic        r_is_wr;
  logic        r_sda_oe;
  logic        r_busy;
  logic [31:0] r_rx_data;
  logic [3:0]  r_rx_mask;
  logic        r_rx_valid;
  logic [3:0]  r_acks;

  logic [1:0] w_idx_nxt;
  logic [7:0] w_rd_byte;
  logic [7:0] w_nxt_byte;
  logic       w_rd_bit;

  // Synchronizers idle high so a reset never looks like a START/STOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
      r_rise_d <= 1'b0;
      r_fall_d <= 1'b0;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      r_rise_d <= w_rise;
      r_fall_d <= w_fall;
    end
  end

  assign w_rise  = r_scl_s2 & ~r_scl_d;
  assign w_fall  = ~r_scl_s2 & r_scl_d;
  assign w_start = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  assign w_idx_nxt  = r_idx - 2'd1;
  assign w_rd_byte  = r_tx[{r_idx, 3'b000} +: 8];
  assign w_nxt_byte = r_tx[{w_idx_nxt, 3'b000} +: 8];
  // r_bitcnt counts SCL pulses already given in this byte, so it selects the next bit to present.
  assign w_rd_bit   = w_rd_byte[3'd7 - r_bitcnt[2:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_bitcnt   <= 4'd0;
      r_idx      <= IDX_FIRST;
      r_shift    <= 8'h00;
      r_tx       <= 32'h0;
      r_is_wr    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= 32'h0;
      r_rx_mask  <= 4'h0;
      r_rx_valid <= 1'b0;
      r_acks     <= 4'hF;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_stop) begin
        r_state    <= IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_rx_valid <= r_is_wr & (|r_rx_mask);
        r_is_wr    <= 1'b0;
      end else if (w_start) begin
        // Also aborts any partial byte: nothing is committed before the 8th bit's falling edge.
        r_state  <= ADDR;
        r_bitcnt <= 4'd0;
        r_idx    <= IDX_FIRST;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ADDR: begin
            if (r_rise_d) begin
              r_shift  <= {r_shift[6:0], r_sda_s2};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (r_fall_d && r_bitcnt == 4'd8) begin
              if (r_shift[7:1] == DEVICE_ADDR) begin
                r_state  <= ADDR_ACK;
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                if (r_shift[0]) begin
                  r_tx    <= tx_data;
                  r_is_wr <= 1'b0;
                end else begin
                  r_is_wr   <= 1'b1;
                  r_rx_mask <= 4'h0;
                end
              end else begin
                r_state <= IGNORE;
                r_busy  <= 1'b0;
                r_is_wr <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            // r_shift[0] still holds the R/W bit here.
            if (r_fall_d) begin
              r_bitcnt <= 4'd0;
              if (r_shift[0]) begin
                r_state  <= RD_BYTE;
                r_sda_oe <= ~w_rd_byte[7];
              end else begin
                r_state  <= WR_BYTE;
                r_sda_oe <= 1'b0;
              end
            end
          end
          WR_BYTE: begin
            if (r_rise_d) begin
              r_shift  <= {r_shift[6:0], r_sda_s2};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (r_fall_d && r_bitcnt == 4'd8) begin
              r_rx_data[{r_idx, 3'b000} +: 8] <= r_shift;
              r_rx_mask[r_idx] <= 1'b1;
              r_state          <= WR_ACK;
              r_sda_oe         <= 1'b1;
            end
          end
          WR_ACK: begin
            if (r_fall_d) begin
              r_state  <= WR_BYTE;
              r_sda_oe <= 1'b0;
              r_idx    <= w_idx_nxt;
              r_bitcnt <= 4'd0;
            end
          end
          RD_BYTE: begin
            if (r_rise_d) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (r_fall_d) begin
              if (r_bitcnt == 4'd8) begin
                r_state  <= RD_ACK;
                r_sda_oe <= 1'b0;
              end else begin
                r_sda_oe <= ~w_rd_bit;
              end
            end
          end
          RD_ACK: begin
            if (r_rise_d) begin
              r_acks[r_idx] <= r_sda_s2;
            end else if (r_fall_d) begin
              if (!r_acks[r_idx]) begin
                r_state  <= RD_BYTE;
                r_idx    <= w_idx_nxt;
                r_bitcnt <= 4'd0;
                r_sda_oe <= ~w_nxt_byte[7];
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign rx_data  = r_rx_data;
  assign rx_mask  = r_rx_mask;
  assign rx_valid = r_rx_valid;
  assign acks     = r_acks;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level master drives SCL/SDA, a transaction-level model predicts outputs.
// Outputs are compared every negedge once the bus has been quiet long enough for the synchronizers.
// Open-drain bus modelled as wired-AND of master drive and target pull-down.
module tb_i2c_target;
  localparam int Q = 8;
  localparam logic [6:0] DEV = 7'h42;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_scl, m_sda;
  logic        scl_i, sda_i;
  logic        sda_o, sda_oe;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic [3:0]  rx_mask;
  logic        rx_valid;
  logic        busy;
  logic [3:0]  acks;

  always #5 clk = ~clk;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  i2c_target #(.DEVICE_ADDR(DEV), .BYTE_START(3)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
    .sda_o(sda_o), .sda_oe(sda_oe), .tx_data(tx_data),
    .rx_data(rx_data), .rx_mask(rx_mask), .rx_valid(rx_valid),
    .busy(busy), .acks(acks)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model: mode 0 = not addressed, 1 = addressed write, 2 = addressed read.
  logic [31:0] e_rx_data = 32'h0;
  logic [3:0]  e_mask = 4'h0;
  logic [3:0]  e_acks = 4'hF;
  logic        e_busy = 1'b0;
  logic        e_wr = 1'b0;
  logic        e_quiet = 1'b0;
  logic [31:0] e_tx = 32'h0;
  int          e_mode = 0;
  int          e_idx = 3;
  int          e_vld = 0;
  int          vld_seen = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rx_valid) vld_seen++;
    if (chk_en) begin
      chk("rx_data", rx_data, e_rx_data);
      chk("rx_mask", {28'h0, rx_mask}, {28'h0, e_mask});
      chk("acks", {28'h0, acks}, {28'h0, e_acks});
      chk("busy", {31'h0, busy}, {31'h0, e_busy});
      chk("rx_valid_count", vld_seen, e_vld);
      chk("sda_o", {31'h0, sda_o}, 32'h0);
      if (e_quiet) chk("quiet_sda_oe", {31'h0, sda_oe}, 32'h0);
    end
  end

  // One quarter SCL period; outputs may be in flux for the first cycles after a line change.
  task automatic wq();
    chk_en = 1'b0;
    repeat (5) @(posedge clk);
    chk_en = 1'b1;
    repeat (Q - 5) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    wq(); m_sda = b; wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wq(); m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); b = sda_i; wq(); m_scl = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  // Clock out pulses until the target lets SDA go high (it may be presenting read data).
  task automatic drain();
    for (int k = 0; k < 10 && sda_i == 1'b0; k++) begin
      m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
    end
  endtask

  task automatic do_start();
    m_sda = 1'b1; wq();
    if (m_scl == 1'b0) drain();
    m_scl = 1'b1; wq();
    m_sda = 1'b0;
    e_idx = 3; e_quiet = 1'b0;
    wq(); m_scl = 1'b0;
  endtask

  task automatic do_stop();
    wq(); m_sda = 1'b1; wq();
    drain();
    m_sda = 1'b0; wq(); m_scl = 1'b1; wq();
    m_sda = 1'b1;
    if (e_wr && e_mask != 4'h0) e_vld++;
    e_busy = 1'b0; e_wr = 1'b0; e_mode = 0; e_quiet = 1'b0;
    wq();
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw, output logic nack);
    send8({a, rw});
    if (a == DEV) begin
      e_busy = 1'b1;
      if (rw) begin e_tx = tx_data; e_wr = 1'b0; e_mode = 2; end
      else begin e_wr = 1'b1; e_mask = 4'h0; e_mode = 1; end
    end else begin
      e_busy = 1'b0; e_wr = 1'b0; e_mode = 0; e_quiet = 1'b1;
    end
    recv_bit(nack);
    chk("addr_ack", {31'h0, nack}, {31'h0, (a != DEV)});
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic nack);
    send8(d);
    if (e_mode == 1) begin
      e_rx_data[e_idx*8 +: 8] = d;
      e_mask[e_idx] = 1'b1;
    end
    recv_bit(nack);
    chk("data_ack", {31'h0, nack}, {31'h0, (e_mode != 1)});
    if (e_mode == 1) e_idx = (e_idx + 3) % 4;
  endtask

  task automatic rd_byte(input logic a, output logic [7:0] got);
    logic b;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      got = {got[6:0], b};
    end
    chk("rd_byte", {24'h0, got}, {24'h0, e_tx[e_idx*8 +: 8]});
    wq(); m_sda = a; wq(); m_scl = 1'b1;
    e_acks[e_idx] = a;
    wq(); wq(); m_scl = 1'b0;
    if (a == 1'b0) e_idx = (e_idx + 3) % 4;
    else begin e_mode = 0; e_quiet = 1'b1; end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        nk, b;
    logic [7:0]  got;
    logic [31:0] bus;
    int          nacks, v0, n;
    logic [6:0]  a;
    logic        rw, rep;

    reset = 1'b0; m_scl = 1'b1; m_sda = 1'b1; tx_data = 32'h0;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("rst_sda_o", {31'h0, sda_o}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_rx_mask", {28'h0, rx_mask}, 32'h0);
    chk("rst_rx_data", rx_data, 32'h0);
    chk("rst_acks", {28'h0, acks}, 32'hF);
    reset = 1'b1;
    wq(); wq();

    // Four-byte write, all bytes ACKed.
    v0 = e_vld; nacks = 0;
    do_start();
    addr_phase(DEV, 1'b0, nk); if (!nk) nacks++;
    wr_byte(8'hDE, nk); if (!nk) nacks++;
    wr_byte(8'hAD, nk); if (!nk) nacks++;
    wr_byte(8'hBE, nk); if (!nk) nacks++;
    wr_byte(8'hEF, nk); if (!nk) nacks++;
    do_stop();
    chk("w4_ack_count", nacks, 5);
    chk("w4_rx_data", rx_data, 32'hDEADBEEF);
    chk("w4_rx_mask", {28'h0, rx_mask}, 32'hF);
    chk("w4_valid_pulses", vld_seen - v0, 1);

    // Four-byte read with ACKs; tx_data changes after the latch point.
    v0 = vld_seen; tx_data = 32'h12345678; bus = 32'h0;
    do_start();
    addr_phase(DEV, 1'b1, nk);
    tx_data = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      rd_byte(1'b0, got);
      bus = {bus[23:0], got};
    end
    do_stop();
    chk("r4_bus_bytes", bus, 32'h12345678);
    chk("r4_acks", {28'h0, acks}, 32'h0);
    chk("r4_no_valid", vld_seen - v0, 0);

    // Foreign address: target stays silent and state is untouched.
    do_start();
    addr_phase(7'h43, 1'b0, nk);
    wr_byte(8'h55, nk);
    chk("foreign_busy", {31'h0, busy}, 32'h0);
    do_stop();
    chk("foreign_rx_mask", {28'h0, rx_mask}, 32'hF);

    // Single-byte write lands in the top byte only.
    v0 = vld_seen;
    do_start();
    addr_phase(DEV, 1'b0, nk);
    wr_byte(8'hA5, nk);
    do_stop();
    chk("w1_rx_data", rx_data, 32'hA5ADBEEF);
    chk("w1_rx_mask", {28'h0, rx_mask}, 32'h8);
    chk("w1_valid_pulses", vld_seen - v0, 1);

    // Master NACKs the first read byte.
    tx_data = $urandom;
    do_start();
    addr_phase(DEV, 1'b1, nk);
    rd_byte(1'b1, got);
    wq();
    chk("nack_acks", {28'h0, acks}, 32'h8);
    chk("nack_sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("nack_busy_held", {31'h0, busy}, 32'h1);
    do_stop();
    chk("nack_busy_cleared", {31'h0, busy}, 32'h0);

    // Reset during bit 4 of a read byte whose bits are all 0.
    tx_data = 32'h00FFFFFF;
    do_start();
    addr_phase(DEV, 1'b1, nk);
    for (int i = 0; i < 3; i++) recv_bit(b);
    wq(); m_sda = 1'b1; wq(); m_scl = 1'b1; wq();
    chk("pre_reset_sda_oe", {31'h0, sda_oe}, 32'h1);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    e_rx_data = 32'h0; e_mask = 4'h0; e_acks = 4'hF; e_busy = 1'b0;
    e_wr = 1'b0; e_mode = 0; e_quiet = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    m_scl = 1'b1; m_sda = 1'b1; reset = 1'b1;
    wq(); wq();
    v0 = vld_seen;
    do_start();
    addr_phase(DEV, 1'b0, nk);
    wr_byte(8'h11, nk);
    do_stop();
    chk("post_reset_rx_data", rx_data, 32'h11000000);
    chk("post_reset_rx_mask", {28'h0, rx_mask}, 32'h8);
    chk("post_reset_valid", vld_seen - v0, 1);

    // Randomized transactions, optionally chained with repeated START.
    for (int t = 0; t < 16; t++) begin
      tx_data = $urandom;
      do_start();
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = DEV;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = a ^ 7'h01;
      end
      addr_phase(a, rw, nk);
      tx_data = $urandom;
      if (e_mode == 2) begin
        n = $urandom_range(1, 5);
        for (int j = 0; j < n && e_mode == 2; j++)
          rd_byte(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, got);
      end else begin
        n = (e_mode == 1) ? $urandom_range(1, 6) : $urandom_range(1, 2);
        for (int j = 0; j < n; j++) wr_byte(8'($urandom), nk);
      end
      rep = (t != 15) && ($urandom_range(0, 3) == 0);
      if (!rep) do_stop();
    end
    wq(); wq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h42, the 7-bit bus address this target answers to.
REQ-002 SHALL have parameter BYTE_START, default 3, the byte index used first in each data phase (bytes run 3,2,1,0; 3 = data[31:24]).
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets immediately.
REQ-005 scl_i  input  1  raw bus SCL, asynchronous to clk.
REQ-006 sda_i  input  1  raw bus SDA, asynchronous to clk.
REQ-007 sda_o  output  1  constant 0; open-drain drive value.
REQ-008 sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-009 tx_data  input  32  read data, captured at address-ACK of a read.
REQ-010 rx_data  output  32  bytes received during writes.
REQ-011 rx_mask  output  4  bit i set = byte i written in the last write transaction.
REQ-012 rx_valid  output  1  one-cycle pulse: write transaction ended with at least one byte.
REQ-013 busy  output  1  1 from addressed START to STOP/abort.
REQ-014 acks  output  4  bit i = master's ACK/NACK level sampled after read byte i (0 = ACK).

Function
REQ-015 SHALL pass scl_i and sda_i through two-flop synchronizers; all detection uses synchronized values and their previous-cycle copies.
REQ-016 SHALL detect START as synced SDA 1->0 while synced SCL stays 1, and STOP as synced SDA 0->1 while SCL stays 1; neither is a data bit.
REQ-017 SHALL sample SDA on the clk cycle after a synced SCL rising edge and change sda_oe only on the cycle after a synced SCL falling edge.
REQ-018 States SHALL be IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-019 START in any state SHALL enter ADDR with bit count 0 and byte index BYTE_START; repeated START is legal.
REQ-020 ADDR SHALL shift 8 bits MSB first (7 address bits, then R/W, 1 = read).
REQ-021 On address mismatch SHALL enter IGNORE, keep sda_oe 0, and leave IGNORE only on START or STOP.
REQ-022 On match SHALL go to ADDR_ACK, assert sda_oe for exactly the 9th SCL pulse (falling edge after bit 8 through next falling edge), and set busy.
REQ-023 Read match SHALL latch tx_data at the falling edge that starts ADDR_ACK.
REQ-024 WR_BYTE SHALL shift 8 bits MSB first, write the byte into rx_data[index*8 +: 8], set rx_mask[index], then ACK in WR_ACK as in REQ-022.
REQ-025 After each ACK the byte index SHALL decrement, wrapping 0 -> 3; a fifth byte overwrites byte 3.
REQ-026 RD_BYTE SHALL drive bit 7..0 of latched byte [index]: sda_oe = ~bit, updated on each SCL falling edge, first bit on the falling edge ending the ACK pulse.
REQ-027 RD_ACK SHALL release SDA, sample master ACK into acks[index]; ACK (0) -> next byte in RD_BYTE; NACK (1) -> IGNORE.
REQ-028 rx_mask SHALL clear at each addressed write START; rx_data bytes not written keep prior values.
REQ-029 On STOP: rx_valid pulses iff the transaction was a write with rx_mask != 0; busy clears the same cycle; state -> IDLE; sda_oe -> 0.
REQ-030 STOP or START arriving mid-byte SHALL abort the byte, releasing SDA without committing it; START with STOP in the same cycle is impossible by construction.
REQ-031 Target SHALL never stretch SCL.

Reset
REQ-032 While reset = 0: state IDLE, sda_oe 0, sda_o 0, busy 0, rx_valid 0, rx_mask 0, rx_data 0, acks 4'hF, synchronizer flops 1.
REQ-033 Reset asserted mid-transfer SHALL release SDA asynchronously; after release the block ignores bus activity until the next START.

Verification
REQ-034 Write 0x84, bytes 0xDE,0xAD,0xBE,0xEF, STOP -> 5 ACKs, rx_data 0xDEADBEEF, rx_mask 4'hF, one rx_valid pulse.
REQ-035 Read 0x85 with tx_data 0x12345678, master ACKs 4 bytes then STOP -> bus bytes 0x12,0x34,0x56,0x78, acks 4'h0, no rx_valid.
REQ-036 Write to 0x86 (address 0x43) -> SDA never driven, busy stays 0, rx_mask unchanged.
REQ-037 Write 0x84, byte 0xA5, STOP -> rx_data[31:24] 0xA5, rx_mask 4'h8, rx_valid pulse; lower bytes unchanged.
REQ-038 Read 0x85, master NACKs after first byte -> acks[3] 1, SDA released, next STOP clears busy.
REQ-039 Reset = 0 during bit 4 of read byte -> sda_oe 0 within the same clk, busy 0; next START/write 0x84 0x11 STOP completes normally.
